serial_addsub: RTL

- Multi-nibble add/subtract engine, sequential.
- Accepts wide operands plus an add/sub control over a valid/ready handshake.
- Processes one 4-bit nibble per clock, LSB nibble first, through a nibble add/sub slice with carry/borrow chaining.
- Presents the full-width result and the final carry/borrow downstream over a second valid/ready handshake.
- Sits directly upstream of, and extends, the team's combinational 4-bit adder/subtractor semantics to wider words.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/nibble_addsub_ci.sv | 26 ++
 rtl/serial_addsub.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the serial nibble add/subtract engine.
package addsub_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/nibble_addsub_ci.sv
// Combinational 4-bit add/subtract slice with carry/borrow chain in and out.
module nibble_addsub_ci
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ctrl,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] r;

    // 5-bit arithmetic: bit 4 is the carry on add and the borrow on subtract
    always_comb begin
        if (ctrl == OP_SUB) begin
            r = {1'b0, a} - {1'b0, b} - (NIBBLE_W+1)'(ci);
        end else begin
            r = {1'b0, a} + {1'b0, b} + (NIBBLE_W+1)'(ci);
        end
        s  = r[NIBBLE_W-1:0];
        co = r[NIBBLE_W];
    end

endmodule

// File: rtl/serial_addsub.sv
// Multi-nibble add/subtract engine, one nibble per clock, LSB first.
// Optional signed-overflow output ovf enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                     ctrl,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
    output logic                     cb,
    output logic                     ovf
`else
    output logic                     cb
`endif
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned IDX_W = $clog2(NIBBLES);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             chain_q, chain_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic             op_q, op_d;
    logic             in_ready_d, out_valid_d, cb_d;
    logic [W-1:0]     result_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_co;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_d;
`endif

    // Single slice shared across all nibble positions via the index mux
    assign nib_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign nib_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    nibble_addsub_ci u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .ctrl (op_q),
        .ci   (chain_q),
        .s    (nib_s),
        .co   (nib_co)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        chain_d     = chain_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        result_d    = result;
        cb_d        = cb;
`ifdef SERIAL_ADDSUB_OVF_EN
        ovf_d       = ovf;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = ctrl;
                    chain_d    = 1'b0;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                result_d[NIBBLE_W*idx_q +: NIBBLE_W] = nib_s;
                chain_d = nib_co;
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    cb_d        = nib_co;
`ifdef SERIAL_ADDSUB_OVF_EN
                    // Sign of the final result is the top bit of the last nibble
                    ovf_d = (nib_s[NIBBLE_W-1] != a_q[W-1]) &&
                            ((op_q == OP_SUB) ? (a_q[W-1] != b_q[W-1])
                                              : (a_q[W-1] == b_q[W-1]));
`endif
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = IDX_W'(idx_q + 1'b1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            chain_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OP_ADD;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            cb        <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chain_q   <= chain_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            result    <= result_d;
            cb        <= cb_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf       <= ovf_d;
`endif
        end
    end

endmodule
